// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame states, parity
// selectors and the idle (mark) line level.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: XOR-reduce of the payload, inverted for odd parity.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: handshakes a byte in, then sequences
// start, serializer-driven data, optional parity and stop bits onto tx_out.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic [DATA_WIDTH-1:0] ser_p_data,
  output logic                  data_ack,
  output logic                  tx_out,
  output logic                  busy
);

  tx_state_t state;
  logic      par_en_q;
  logic      parity_q;
  logic      parity_next;
  logic      accept;

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (p_data),
    .par_typ (par_typ),
    .parity  (parity_next)
  );

  // A new byte can be taken while idle or during the stop bit of the
  // previous frame, which is what gives gapless back-to-back frames.
  assign accept   = data_valid && (state == ST_IDLE || state == ST_STOP);
  assign data_ack = accept;

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // the reset also clears the byte register so ser_p_data is never X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ser_en     <= 1'b0;
      ser_p_data <= '0;
      par_en_q   <= 1'b0;
      parity_q   <= 1'b0;
    end else begin
      ser_en <= 1'b0;
      if (accept) begin
        ser_p_data <= p_data;
        par_en_q   <= par_en;
        parity_q   <= parity_next;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_START;
            ser_en <= 1'b1;
          end
        end
        ST_START:  state <= ST_DATA;
        ST_DATA: begin
          if (ser_done) state <= par_en_q ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: state <= ST_STOP;
        ST_STOP: begin
          if (accept) begin
            state  <= ST_START;
            ser_en <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // The line level is decoded only from flop outputs, so it cannot glitch
  // on upstream handshake activity.
  always_comb begin
    tx_out = LINE_IDLE;
    case (state)
      ST_START:  tx_out = 1'b0;
      ST_DATA:   tx_out = ser_data;
      ST_PARITY: tx_out = parity_q;
      default:   tx_out = LINE_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule
